// File: rtl/complex_pkg.sv
// ---------------------------------------------------------------------------
// complex_pkg
//   Definitions shared by the complex-math cores: the FSM state encoding of
//   the iterative complex divider and its latency helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package complex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } cdiv_state_t;

    // Enabled cycles from the accept edge to the output strobe edge.
    function automatic int cdiv_latency(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

endpackage

// File: rtl/udiv_iter.sv
// ---------------------------------------------------------------------------
// udiv_iter
//   Unsigned iterative restoring divider, one quotient bit per step.
//   Computes (i_num << SH) / i_den as a QW-bit quotient. Sequencing comes
//   from the parent: i_step advances one bit, i_first marks the first step
//   and makes that step start from the fresh dividend instead of the
//   internal registers, so no separate load cycle is needed.
//   The caller guarantees the quotient fits in QW bits (for a nonzero
//   divisor), which means the dividend bits above the QW quotient positions
//   are already smaller than the divisor and can seed the remainder.
//
//   Ports
//     clock, resetn : clock, async active-low reset
//     i_step        : perform one division step this cycle
//     i_first       : this step is the first of a new division
//     i_num         : unsigned numerator magnitude (NW bits)
//     i_den         : unsigned divisor (DW bits)
//     o_quo         : quotient, valid after QW steps
// ---------------------------------------------------------------------------
module udiv_iter #(
    parameter int NW = 32,
    parameter int SH = 15,
    parameter int DW = 32,
    parameter int QW = 31
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          i_step,
    input  logic          i_first,
    input  logic [NW-1:0] i_num,
    input  logic [DW-1:0] i_den,
    output logic [QW-1:0] o_quo
);

    localparam int XW = NW + SH;

    logic [DW-1:0] r_rem;
    logic [QW-1:0] r_acc;

    logic [XW-1:0] w_x;
    logic [DW-1:0] w_x_hi;
    logic [QW-1:0] w_x_lo;
    logic [DW-1:0] w_rem_cur;
    logic [QW-1:0] w_acc_cur;
    logic [DW:0]   w_trial;
    logic [DW:0]   w_den_ext;
    logic [DW:0]   w_diff;
    logic          w_ge;
    logic [DW-1:0] w_rem_next;
    logic [QW-1:0] w_acc_next;

    assign w_x    = XW'(i_num) << SH;
    assign w_x_hi = DW'(w_x >> QW);
    assign w_x_lo = w_x[QW-1:0];

    assign w_rem_cur = i_first ? w_x_hi : r_rem;
    assign w_acc_cur = i_first ? w_x_lo : r_acc;

    // r_acc shifts dividend bits out of its top and quotient bits into its
    // bottom; after QW steps it holds only the quotient.
    assign w_trial    = {w_rem_cur, w_acc_cur[QW-1]};
    assign w_den_ext  = {1'b0, i_den};
    assign w_diff     = w_trial - w_den_ext;
    assign w_ge       = (w_trial >= w_den_ext);
    assign w_rem_next = w_ge ? DW'(w_diff) : DW'(w_trial);
    assign w_acc_next = {w_acc_cur[QW-2:0], w_ge};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rem <= '0;
            r_acc <= '0;
        end else if (i_step) begin
            r_rem <= w_rem_next;
            r_acc <= w_acc_next;
        end
    end

    assign o_quo = r_acc;

endmodule

// File: rtl/complex_div.sv
// ---------------------------------------------------------------------------
// complex_div
//   Iterative complex divider p = a / b. The numerator a*conj(b) and the
//   denominator |b|^2 are formed in one registered multiply stage, then two
//   restoring dividers (real and imaginary) run in parallel off one shared
//   down-counter. Output is signed AWIDTH+BWIDTH bits with BWIDTH-1
//   fractional bits, truncated toward zero.
//
//   Ports
//     clock, resetn    : clock, async active-low reset
//     enable           : clock enable, freezes all state when low
//     ai, aq           : signed numerator (real, imaginary)
//     bi, bq           : signed denominator (real, imaginary)
//     input_strobe     : operands valid, taken only while ready is high
//     ready            : block idle and able to accept operands
//     pi, pq           : signed quotient, held between strobes
//     div_zero         : denominator was zero, valid with output_strobe
//     output_strobe    : one enabled-cycle pulse marking a new result
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for input_strobe; ready high
//   MULT    | register a*conj(b) and |b|^2, load the step counter
//   DIV     | one quotient bit per enabled cycle, AWIDTH+BWIDTH-1 cycles
//   DONE    | apply sign, register outputs, pulse output_strobe
// ---------------------------------------------------------------------------
module complex_div
    import complex_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            enable,
    input  logic signed [AWIDTH-1:0]        ai,
    input  logic signed [AWIDTH-1:0]        aq,
    input  logic signed [BWIDTH-1:0]        bi,
    input  logic signed [BWIDTH-1:0]        bq,
    input  logic                            input_strobe,
    output logic                            ready,
    output logic signed [AWIDTH+BWIDTH-1:0] pi,
    output logic signed [AWIDTH+BWIDTH-1:0] pq,
    output logic                            div_zero,
    output logic                            output_strobe
);

    localparam int PW   = AWIDTH + BWIDTH;
    localparam int FRAC = BWIDTH - 1;
    localparam int LAT  = cdiv_latency(AWIDTH, BWIDTH);
    localparam int QW   = LAT - 2;
    localparam int DW   = 2 * BWIDTH;
    localparam int CW   = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);

    cdiv_state_t             r_state;
    logic [CW-1:0]           r_cnt;
    logic signed [AWIDTH-1:0] r_ai;
    logic signed [AWIDTH-1:0] r_aq;
    logic signed [BWIDTH-1:0] r_bi;
    logic signed [BWIDTH-1:0] r_bq;
    logic signed [PW:0]      r_ni;
    logic signed [PW:0]      r_nq;
    logic [DW-1:0]           r_d;
    logic signed [PW-1:0]    r_pi;
    logic signed [PW-1:0]    r_pq;
    logic                    r_div_zero;
    logic                    r_ostb;

    logic signed [PW:0]      w_ai_e;
    logic signed [PW:0]      w_aq_e;
    logic signed [PW:0]      w_bi_e;
    logic signed [PW:0]      w_bq_e;
    logic signed [PW:0]      w_ni_p;
    logic signed [PW:0]      w_nq_p;
    logic signed [DW:0]      w_bi_d;
    logic signed [DW:0]      w_bq_d;
    logic signed [DW:0]      w_d_p;
    logic [PW-1:0]           w_ni_mag;
    logic [PW-1:0]           w_nq_mag;
    logic                    w_step;
    logic                    w_first;
    logic [QW-1:0]           w_qi;
    logic [QW-1:0]           w_qq;
    logic signed [PW-1:0]    w_pi_mag;
    logic signed [PW-1:0]    w_pq_mag;
    logic signed [PW-1:0]    w_pi_res;
    logic signed [PW-1:0]    w_pq_res;
    logic                    w_dz;

    // Operands widened first so every product and sum is exact; the
    // worst case (-2^(W-1))^2 * 2 needs PW+1 signed bits.
    assign w_ai_e = (PW+1)'(r_ai);
    assign w_aq_e = (PW+1)'(r_aq);
    assign w_bi_e = (PW+1)'(r_bi);
    assign w_bq_e = (PW+1)'(r_bq);
    assign w_ni_p = w_ai_e * w_bi_e + w_aq_e * w_bq_e;
    assign w_nq_p = w_aq_e * w_bi_e - w_ai_e * w_bq_e;

    assign w_bi_d = (DW+1)'(r_bi);
    assign w_bq_d = (DW+1)'(r_bq);
    assign w_d_p  = w_bi_d * w_bi_d + w_bq_d * w_bq_d;

    // |N| <= 2^(PW-1), so the magnitude fits in PW unsigned bits.
    assign w_ni_mag = r_ni[PW] ? PW'(-r_ni) : PW'(r_ni);
    assign w_nq_mag = r_nq[PW] ? PW'(-r_nq) : PW'(r_nq);

    assign w_step  = enable && (r_state == ST_DIV);
    assign w_first = (r_cnt == CNT_LOAD);

    udiv_iter #(
        .NW (PW),
        .SH (FRAC),
        .DW (DW),
        .QW (QW)
    ) u_div_i (
        .clock   (clock),
        .resetn  (resetn),
        .i_step  (w_step),
        .i_first (w_first),
        .i_num   (w_ni_mag),
        .i_den   (r_d),
        .o_quo   (w_qi)
    );

    udiv_iter #(
        .NW (PW),
        .SH (FRAC),
        .DW (DW),
        .QW (QW)
    ) u_div_q (
        .clock   (clock),
        .resetn  (resetn),
        .i_step  (w_step),
        .i_first (w_first),
        .i_num   (w_nq_mag),
        .i_den   (r_d),
        .o_quo   (w_qq)
    );

    assign w_pi_mag = signed'(PW'(w_qi));
    assign w_pq_mag = signed'(PW'(w_qq));
    assign w_pi_res = r_ni[PW] ? -w_pi_mag : w_pi_mag;
    assign w_pq_res = r_nq[PW] ? -w_pq_mag : w_pq_mag;
    assign w_dz     = (r_d == '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ai       <= '0;
            r_aq       <= '0;
            r_bi       <= '0;
            r_bq       <= '0;
            r_ni       <= '0;
            r_nq       <= '0;
            r_d        <= '0;
            r_pi       <= '0;
            r_pq       <= '0;
            r_div_zero <= 1'b0;
            r_ostb     <= 1'b0;
        end else if (enable) begin
            r_ostb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (input_strobe) begin
                        r_ai    <= ai;
                        r_aq    <= aq;
                        r_bi    <= bi;
                        r_bq    <= bq;
                        r_state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    r_ni    <= w_ni_p;
                    r_nq    <= w_nq_p;
                    r_d     <= DW'(w_d_p);
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_DIV;
                end
                ST_DIV: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_pi       <= w_dz ? '0 : w_pi_res;
                    r_pq       <= w_dz ? '0 : w_pq_res;
                    r_div_zero <= w_dz;
                    r_ostb     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready         = (r_state == ST_IDLE);
    assign pi            = r_pi;
    assign pq            = r_pq;
    assign div_zero      = r_div_zero;
    assign output_strobe = r_ostb;

endmodule

// File: tb/tb_complex_div.sv
module tb_complex_div;

    localparam int LAT    = 33;
    localparam int PERIOD = 34;

    logic               clock = 1'b0;
    logic               resetn;
    logic               enable;
    logic signed [15:0] ai, aq, bi, bq;
    logic               input_strobe;
    logic               ready;
    logic signed [31:0] pi, pq;
    logic               div_zero;
    logic               output_strobe;

    complex_div dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .ai            (ai),
        .aq            (aq),
        .bi            (bi),
        .bq            (bq),
        .input_strobe  (input_strobe),
        .ready         (ready),
        .pi            (pi),
        .pq            (pq),
        .div_zero      (div_zero),
        .output_strobe (output_strobe)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic signed [31:0] pi;
        logic signed [31:0] pq;
        logic               dz;
        logic [31:0]        acc_en;
    } exp_t;

    exp_t sb[$];
    exp_t exp_next;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   acc_cnt = 0;
    int   strobe_cnt = 0;
    int   last_strobe_cyc = 0;
    int   acc_cycs[$];

    // Accept capture on the edge (pre-edge values), result check 1 ns later.
    always @(posedge clock) begin
        logic e;
        logic acc;
        exp_t ent;
        e   = enable;
        acc = resetn && enable && input_strobe && ready;
        cyc++;
        if (e) en_cnt++;
        if (acc) begin
            ent        = exp_next;
            ent.acc_en = 32'(en_cnt);
            sb.push_back(ent);
            acc_cnt++;
            acc_cycs.push_back(cyc);
        end
        #1;
        if (resetn && e && output_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cycle=%0d pi=%0d pq=%0d", cyc, pi, pq);
            end else begin
                ent = sb.pop_front();
                total++;
                if (pi !== ent.pi) begin
                    bad++;
                    $display("FAIL pi got=%0d want=%0d", pi, ent.pi);
                end
                total++;
                if (pq !== ent.pq) begin
                    bad++;
                    $display("FAIL pq got=%0d want=%0d", pq, ent.pq);
                end
                total++;
                if (div_zero !== ent.dz) begin
                    bad++;
                    $display("FAIL div_zero got=%0b want=%0b", div_zero, ent.dz);
                end
                total++;
                if ((en_cnt - int'(ent.acc_en)) !== LAT) begin
                    bad++;
                    $display("FAIL latency_enabled got=%0d want=%0d", en_cnt - int'(ent.acc_en), LAT);
                end
            end
        end
    end

    function automatic exp_t model(input logic signed [15:0] a_i, input logic signed [15:0] a_q,
                                   input logic signed [15:0] b_i, input logic signed [15:0] b_q);
        longint ni, nq, d;
        exp_t   r;
        ni = longint'(a_i) * longint'(b_i) + longint'(a_q) * longint'(b_q);
        nq = longint'(a_q) * longint'(b_i) - longint'(a_i) * longint'(b_q);
        d  = longint'(b_i) * longint'(b_i) + longint'(b_q) * longint'(b_q);
        r.acc_en = '0;
        if (d == 0) begin
            r.pi = '0;
            r.pq = '0;
            r.dz = 1'b1;
        end else begin
            r.pi = 32'((ni * 32768) / d);
            r.pq = 32'((nq * 32768) / d);
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic set_op(input logic signed [15:0] a_i, input logic signed [15:0] a_q,
                          input logic signed [15:0] b_i, input logic signed [15:0] b_q,
                          input exp_t e);
        ai       = a_i;
        aq       = a_q;
        bi       = b_i;
        bq       = b_q;
        exp_next = e;
    endtask

    task automatic do_op(input logic signed [15:0] a_i, input logic signed [15:0] a_q,
                         input logic signed [15:0] b_i, input logic signed [15:0] b_q,
                         input exp_t e);
        int start;
        int n;
        @(negedge clock);
        set_op(a_i, a_q, b_i, b_q, e);
        input_strobe = 1'b1;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 300) begin
            @(posedge clock);
            #2;
            n++;
        end
        total++;
        if (acc_cnt == start) begin
            bad++;
            $display("FAIL accept_timeout got=no_accept want=accept");
        end else begin
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_ready got=%0b want=0", ready);
            end
        end
        @(negedge clock);
        input_strobe = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL result_timeout got=%0d_pending want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        enable       = 1'b1;
        input_strobe = 1'b0;
        ai = '0; aq = '0; bi = '0; bq = '0;
        exp_next = '0;
        repeat (3) @(negedge clock);
        total++; if (ready !== 1'b1)         begin bad++; $display("FAIL rst_ready got=%0b want=1", ready); end
        total++; if (output_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%0b want=0", output_strobe); end
        total++; if (div_zero !== 1'b0)      begin bad++; $display("FAIL rst_div_zero got=%0b want=0", div_zero); end
        total++; if (pi !== 32'sd0)          begin bad++; $display("FAIL rst_pi got=%0d want=0", pi); end
        total++; if (pq !== 32'sd0)          begin bad++; $display("FAIL rst_pq got=%0d want=0", pq); end
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        total++; if (strobe_cnt !== 0)       begin bad++; $display("FAIL rst_release_strobe got=%0d want=0", strobe_cnt); end
        total++; if (ready !== 1'b1)         begin bad++; $display("FAIL rst_release_ready got=%0b want=1", ready); end
    endtask

    task automatic test_vectors();
        int   t_ai[7] = '{100, 3, -7, 1, -1, 123, -32768};
        int   t_aq[7] = '{0, 4, 0, 0, 0, -45, -32768};
        int   t_bi[7] = '{2, 1, 2, 3, 3, 0, 1};
        int   t_bq[7] = '{0, 1, 0, 0, 0, 0, 0};
        int   t_pi[7] = '{1638400, 114688, -114688, 10922, -10922, 0, -1073741824};
        int   t_pq[7] = '{0, 16384, 0, 0, 0, 0, -1073741824};
        int   t_dz[7] = '{0, 0, 0, 0, 0, 1, 0};
        exp_t e;
        int   s0;
        for (int i = 0; i < 7; i++) begin
            e.pi     = 32'(t_pi[i]);
            e.pq     = 32'(t_pq[i]);
            e.dz     = 1'(t_dz[i]);
            e.acc_en = '0;
            s0 = strobe_cnt;
            do_op(16'(t_ai[i]), 16'(t_aq[i]), 16'(t_bi[i]), 16'(t_bq[i]), e);
            wait_done();
            total++;
            if ((last_strobe_cyc - acc_cycs[acc_cycs.size()-1]) !== LAT) begin
                bad++;
                $display("FAIL latency_cycles vec=%0d got=%0d want=%0d", i,
                         last_strobe_cyc - acc_cycs[acc_cycs.size()-1], LAT);
            end
            repeat (6) @(negedge clock);
            total++;
            if (strobe_cnt !== s0 + 1) begin
                bad++;
                $display("FAIL strobe_count vec=%0d got=%0d want=%0d", i, strobe_cnt - s0, 1);
            end
            total++;
            if (pi !== e.pi || pq !== e.pq) begin
                bad++;
                $display("FAIL hold vec=%0d got=%0d,%0d want=%0d,%0d", i, pi, pq, e.pi, e.pq);
            end
        end
    endtask

    task automatic test_random();
        logic signed [15:0] r_ai, r_aq, r_bi, r_bq;
        for (int i = 0; i < 10; i++) begin
            r_ai = 16'($urandom);
            r_aq = 16'($urandom);
            if (i == 0) begin
                r_bi = -16'sd32768;
                r_bq = -16'sd32768;
            end else if (i < 5) begin
                r_bi = 16'($urandom_range(0, 40)) - 16'sd20;
                r_bq = 16'($urandom_range(0, 40)) - 16'sd20;
            end else begin
                r_bi = 16'($urandom);
                r_bq = 16'($urandom);
            end
            do_op(r_ai, r_aq, r_bi, r_bq, model(r_ai, r_aq, r_bi, r_bq));
            wait_done();
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        @(negedge clock);
        set_op(16'sd5, -16'sd3, 16'sd1, 16'sd2, model(16'sd5, -16'sd3, 16'sd1, 16'sd2));
        n0 = acc_cycs.size();
        input_strobe = 1'b1;
        repeat (3 * PERIOD) @(posedge clock);
        @(negedge clock);
        input_strobe = 1'b0;
        total++;
        if ((acc_cycs.size() - n0) !== 3) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d want=3", acc_cycs.size() - n0);
        end else begin
            total++;
            if ((acc_cycs[n0+1] - acc_cycs[n0]) !== PERIOD) begin
                bad++;
                $display("FAIL b2b_spacing1 got=%0d want=%0d", acc_cycs[n0+1] - acc_cycs[n0], PERIOD);
            end
            total++;
            if ((acc_cycs[n0+2] - acc_cycs[n0+1]) !== PERIOD) begin
                bad++;
                $display("FAIL b2b_spacing2 got=%0d want=%0d", acc_cycs[n0+2] - acc_cycs[n0+1], PERIOD);
            end
        end
        wait_done();
    endtask

    task automatic test_enable_toggle();
        int s0;
        s0 = strobe_cnt;
        fork
            begin
                repeat (120) begin
                    @(negedge clock);
                    enable = ~enable;
                end
                enable = 1'b1;
            end
            begin
                do_op(16'sd300, -16'sd200, 16'sd7, -16'sd3, model(16'sd300, -16'sd200, 16'sd7, -16'sd3));
                wait_done();
            end
        join
        enable = 1'b1;
        repeat (4) @(negedge clock);
        total++;
        if (strobe_cnt !== s0 + 1) begin
            bad++;
            $display("FAIL en_toggle_strobes got=%0d want=1", strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_abort();
        int s0;
        do_op(16'sd1000, 16'sd2000, -16'sd5, 16'sd9, model(16'sd1000, 16'sd2000, -16'sd5, 16'sd9));
        repeat (11) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        total++; if (ready !== 1'b1)         begin bad++; $display("FAIL abort_ready got=%0b want=1", ready); end
        total++; if (output_strobe !== 1'b0) begin bad++; $display("FAIL abort_strobe got=%0b want=0", output_strobe); end
        total++; if (pi !== 32'sd0)          begin bad++; $display("FAIL abort_pi got=%0d want=0", pi); end
        total++; if (div_zero !== 1'b0)      begin bad++; $display("FAIL abort_div_zero got=%0b want=0", div_zero); end
        sb.delete();
        s0 = strobe_cnt;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (45) @(negedge clock);
        total++;
        if (strobe_cnt !== s0) begin
            bad++;
            $display("FAIL abort_no_strobe got=%0d want=0", strobe_cnt - s0);
        end
        do_op(-16'sd1234, 16'sd567, 16'sd89, 16'sd10, model(-16'sd1234, 16'sd567, 16'sd89, 16'sd10));
        wait_done();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_enable_toggle();
        test_reset_abort();
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
